// File: rtl/axc_error_sweeper.sv
// Exhaustive sweep and error grading of an approximate |a-b| circuit.
// Drives every input vector, compares against the exact result, reports.
module axc_error_sweeper #(
  parameter int N_IN         = 4,
  parameter int N_OUT        = 3,
  parameter int ET           = 4,
  parameter int DUT_LAT      = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   dut_in,
  input  logic [N_OUT-1:0]  dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_OUT:0]    max_err,
  output logic [N_IN:0]     mismatch_cnt,
  output logic [N_IN-1:0]   worst_vec,
  output logic [N_IN-1:0]   fail_vec
);

  localparam int H  = N_IN / 2;
  localparam int EW = N_OUT + 1;
  localparam int CW = N_IN + 1;
  localparam int DW = $clog2(DUT_LAT + 1) + 1;
  localparam logic [EW:0] ET_W = (EW + 1)'(ET);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic [N_IN-1:0] dut_in_q, dut_in_d;
  logic [EW-1:0]   max_q, max_d;
  logic [N_IN:0]   mis_q, mis_d;
  logic [N_IN-1:0] worst_q, worst_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            failed_q, failed_d;
  logic            pass_q, pass_d;

  logic            cur_v;
  logic            g_v;
  logic [N_IN-1:0] g_vec;
  logic [EW-1:0]   a_e, b_e, exact, approx, err;
  logic            grade, bad, stop;

  assign cur_v = (state_q == RUN);

  // Expected-value pipeline: the graded vector lines up with dut_out.
  if (DUT_LAT == 0) begin : g_nolat
    assign g_v   = cur_v;
    assign g_vec = dut_in_q;
  end else begin : g_lat
    logic [DUT_LAT-1:0] v_q, v_d;
    logic [N_IN-1:0]    vec_q [DUT_LAT];
    logic [N_IN-1:0]    vec_d [DUT_LAT];

    always_comb begin
      v_d      = '0;
      vec_d[0] = dut_in_q;
      v_d[0]   = cur_v;
      for (int i = 1; i < DUT_LAT; i++) begin
        v_d[i]   = v_q[i-1];
        vec_d[i] = vec_q[i-1];
      end
      if (state_q == IDLE || state_q == DONE)
        v_d = '0;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= '0;
      end else begin
        v_q   <= v_d;
        vec_q <= vec_d;
      end
    end

    assign g_v   = v_q[DUT_LAT-1];
    assign g_vec = vec_q[DUT_LAT-1];
  end

  always_comb begin
    a_e    = EW'(g_vec[N_IN-1:H]);
    b_e    = EW'(g_vec[H-1:0]);
    exact  = (a_e >= b_e) ? a_e - b_e : b_e - a_e;
    approx = {1'b0, dut_out};
    err    = (approx >= exact) ? approx - exact : exact - approx;
  end

  assign grade = g_v && (state_q == RUN || state_q == DRAIN);
  assign bad   = grade && ({1'b0, err} > ET_W);
  assign stop  = bad && (STOP_ON_FAIL != 0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drain_d  = drain_q;
    dut_in_d = dut_in_q;
    max_d    = max_q;
    mis_d    = mis_q;
    worst_d  = worst_q;
    fvec_d   = fvec_q;
    failed_d = failed_q;
    pass_d   = pass_q;

    if (grade) begin
      if (err > max_q) begin
        max_d   = err;
        worst_d = g_vec;
      end
      if (err != '0)
        mis_d = mis_q + (N_IN + 1)'(1);
      if (bad && !failed_q) begin
        failed_d = 1'b1;
        fvec_d   = g_vec;
      end
    end

    unique case (state_q)
      IDLE: begin
        dut_in_d = '0;
        if (start) begin
          cnt_d    = '0;
          max_d    = '0;
          mis_d    = '0;
          worst_d  = '0;
          fvec_d   = '0;
          failed_d = 1'b0;
          pass_d   = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        cnt_d    = cnt_q + CW'(1);
        dut_in_d = cnt_d[N_IN-1:0];
        drain_d  = '0;
        if (cnt_d[N_IN])
          state_d = (DUT_LAT == 0) ? DONE : DRAIN;
      end
      DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (drain_q == DW'(DUT_LAT - 1))
          state_d = DONE;
      end
      DONE: begin
        dut_in_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (stop)
      state_d = DONE;
    if (state_d == DONE && state_q != DONE)
      pass_d = ({1'b0, max_d} <= ET_W) && !stop;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      drain_q  <= '0;
      dut_in_q <= '0;
      max_q    <= '0;
      mis_q    <= '0;
      worst_q  <= '0;
      fvec_q   <= '0;
      failed_q <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      drain_q  <= drain_d;
      dut_in_q <= dut_in_d;
      max_q    <= max_d;
      mis_q    <= mis_d;
      worst_q  <= worst_d;
      fvec_q   <= fvec_d;
      failed_q <= failed_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign pass         = pass_q;
  assign max_err      = max_q;
  assign mismatch_cnt = mis_q;
  assign worst_vec    = worst_q;
  assign fail_vec     = fvec_q;

endmodule

// File: tb/tb_axc_error_sweeper.sv
// Directed bench: ideal, approximate and delayed DUT models across
// default, stop-on-fail and pipelined-DUT sweeper configurations.
module tb_axc_error_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start;
  int         mode0;

  logic [3:0] in0, in1, in2;
  logic [2:0] out0, out1, out2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [3:0] maxe0, maxe1, maxe2;
  logic [4:0] mis0, mis1, mis2;
  logic [3:0] wv0, wv1, wv2;
  logic [3:0] fv0, fv1, fv2;
  logic [2:0] d0a, d0b, d2a, d2b;

  int checks = 0;
  int errors = 0;
  int dn0 = 0;

  axc_error_sweeper u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .dut_in(in0), .dut_out(out0), .busy(busy0), .done(done0),
    .pass(pass0), .max_err(maxe0), .mismatch_cnt(mis0),
    .worst_vec(wv0), .fail_vec(fv0)
  );

  axc_error_sweeper #(.ET(2), .STOP_ON_FAIL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .dut_in(in1), .dut_out(out1), .busy(busy1), .done(done1),
    .pass(pass1), .max_err(maxe1), .mismatch_cnt(mis1),
    .worst_vec(wv1), .fail_vec(fv1)
  );

  axc_error_sweeper #(.DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .dut_in(in2), .dut_out(out2), .busy(busy2), .done(done2),
    .pass(pass2), .max_err(maxe2), .mismatch_cnt(mis2),
    .worst_vec(wv2), .fail_vec(fv2)
  );

  function automatic logic [2:0] exact_f(input logic [3:0] v);
    logic [1:0] a, b;
    a = v[3:2];
    b = v[1:0];
    return (a >= b) ? {1'b0, a - b} : {1'b0, b - a};
  endfunction

  function automatic logic [2:0] approx_f(input logic [3:0] v);
    logic o0, o1;
    o0 = (v[2] & v[3]) | (v[1] & v[3]) | ~v[1] | v[0];
    o1 = ~v[0];
    return {1'b0, o1, o0};
  endfunction

  always_comb begin
    out0 = exact_f(in0);
    if (mode0 == 1) out0 = approx_f(in0);
    else if (mode0 == 2) out0 = d0b;
  end
  assign out1 = approx_f(in1);
  assign out2 = d2b;

  always @(posedge clk) begin
    d0a <= exact_f(in0);
    d0b <= d0a;
    d2a <= exact_f(in2);
    d2b <= d2a;
    if (done0) dn0 <= dn0 + 1;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic done_of(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction

  // Start cycle is cycle 0; returns the cycle in which done was seen.
  task automatic sweep(input int sel, input bit poke, output int cyc);
    @(posedge clk); #1;
    start[sel] = 1'b1;
    @(posedge clk); #1;
    start[sel] = 1'b0;
    cyc = 1;
    for (int n = 0; n < 100; n++) begin
      start[sel] = poke && (cyc == 5 || cyc == 17);
      if (done_of(sel)) break;
      @(posedge clk); #1;
      cyc++;
    end
    if (!done_of(sel)) chk("sweep_done", int'(done_of(sel)), 1);
    @(posedge clk); #1;
    start[sel] = 1'b0;
  endtask

  int cyc;
  int d;

  initial begin
    rst_n = 1'b0;
    start = '0;
    mode0 = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_max", maxe0, 0);
    chk("rst_in", in0, 0);

    mode0 = 0;
    sweep(0, 1'b0, cyc);
    chk("ideal_cyc", cyc, 17);
    chk("ideal_max", maxe0, 0);
    chk("ideal_mis", mis0, 0);
    chk("ideal_pass", pass0, 1);
    chk("ideal_worst", wv0, 0);
    chk("ideal_fvec", fv0, 0);
    chk("ideal_idle_in", in0, 0);
    chk("ideal_idle_done", done0, 0);

    mode0 = 1;
    sweep(0, 1'b0, cyc);
    chk("apx_cyc", cyc, 17);
    chk("apx_max", maxe0, 3);
    chk("apx_mis", mis0, 11);
    chk("apx_worst", wv0, 0);
    chk("apx_fvec", fv0, 0);
    chk("apx_pass", pass0, 1);

    sweep(1, 1'b0, cyc);
    chk("stop_cyc", cyc, 2);
    chk("stop_pass", pass1, 0);
    chk("stop_fvec", fv1, 0);
    chk("stop_max", maxe1, 3);
    chk("stop_mis", mis1, 1);
    chk("stop_busy", busy1, 0);

    sweep(2, 1'b0, cyc);
    chk("lat2_cyc", cyc, 19);
    chk("lat2_max", maxe2, 0);
    chk("lat2_mis", mis2, 0);
    chk("lat2_pass", pass2, 1);

    mode0 = 2;
    sweep(0, 1'b0, cyc);
    chk("lat0_cyc", cyc, 17);
    chk("lat0_mis_nz", int'(mis0 != 0), 1);

    mode0 = 1;
    @(posedge clk); #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1 chk("mid_busy", busy0, 1);
    chk("mid_max", maxe0, 3);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_busy", busy0, 0);
    chk("mrst_done", done0, 0);
    chk("mrst_max", maxe0, 0);
    chk("mrst_mis", mis0, 0);
    chk("mrst_in", in0, 0);
    chk("mrst_pass", pass0, 0);
    d = dn0;
    repeat (20) @(posedge clk);
    #1 chk("mrst_nodone", dn0 - d, 0);
    sweep(0, 1'b0, cyc);
    chk("mrst_cyc", cyc, 17);
    chk("mrst_res_max", maxe0, 3);
    chk("mrst_res_mis", mis0, 11);
    chk("mrst_res_pass", pass0, 1);

    d = dn0;
    sweep(0, 1'b1, cyc);
    chk("poke_cyc", cyc, 17);
    repeat (25) @(posedge clk);
    #1 chk("poke_ndone", dn0 - d, 1);
    chk("poke_busy", busy0, 0);
    chk("poke_max", maxe0, 3);
    chk("poke_mis", mis0, 11);
    chk("poke_worst", wv0, 0);
    chk("poke_fvec", fv0, 0);
    chk("poke_pass", pass0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axc_error_sweeper.md
Name: axc_error_sweeper

Overview:
- Sequencer that exhaustively exercises one approximate combinational circuit under test (DUT) and grades it against the exact absolute-difference function.
- The DUT is a shared-logic SOP approximation with N_IN inputs and N_OUT outputs.
- The block drives every input vector and samples the DUT outputs. It accumulates max error, mismatch count and worst vector, then reports pass/fail against error threshold ET.
- Sits beside the generated approximate netlist in the verification/characterisation harness and sequences that datapath.

Parameters:
- N_IN, 4, DUT input count; must be even; operand width is N_IN/2.
- N_OUT, 3, DUT output count; out0 is the LSB of the approximate result.
- ET, 4, error threshold; the circuit passes when max_err <= ET.
- DUT_LAT, 0, extra DUT pipeline cycles (0 = purely combinational DUT).
- STOP_ON_FAIL, 0, 1 = end the sweep at the first sample with err > ET.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  sweep request, sampled only in IDLE
- dut_in  out  N_IN  registered input vector; bit i drives DUT input in_i
- dut_out  in  N_OUT  DUT outputs; bit j is out_j
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when results are final
- pass  out  1  max_err <= ET, no early stop; held until next start
- max_err  out  N_OUT+1  largest |approx - exact| seen
- mismatch_cnt  out  N_IN+1  number of vectors with err != 0
- worst_vec  out  N_IN  first vector reaching max_err
- fail_vec  out  N_IN  first vector with err > ET (0 if none)

Behaviour:
- Reset: synchronous, rst_n sampled on the clk edge, overrides everything. All outputs go to 0, state goes to IDLE, pipeline valids clear. Reset mid-sweep abandons the sweep; no done pulse.
- Exact model: a = vec[N_IN-1:N_IN/2], b = vec[N_IN/2-1:0]. exact = |a-b|, zero-extended to N_OUT+1 bits. approx = dut_out zero-extended. err = |approx - exact| in N_OUT+1 bits, no saturation needed.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 clears the accumulators and vec counter, then goes to RUN.
  - RUN: presents vector k on dut_in in cycle k+1 after the start cycle, for k = 0..2^N_IN-1. After the last vector goes to DRAIN.
  - DRAIN: stays until the last in-flight sample is consumed (DUT_LAT cycles), then goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. dut_in returns to 0 in IDLE.
- Sampling: vector k on dut_in during cycle t is graded with dut_out at the edge ending cycle t+DUT_LAT. Expected value and index travel in a DUT_LAT-deep shift register with a valid bit.
- Latency: with no early stop, done is high in cycle 2^N_IN+DUT_LAT+1, counting the start cycle as cycle 0 (cycle 17 for defaults).
- Accumulators (per valid sample):
  - max_err updates when err > max_err; worst_vec updates on the same condition (strict >, so the first occurrence is kept).
  - mismatch_cnt increments when err != 0.
  - fail_vec latches only on the first err > ET.
- pass: computed at DONE; held with all results until the next accepted start.
- STOP_ON_FAIL=1: the first sample with err > ET forces DONE on the next cycle. In-flight samples are discarded, and pass=0.
- start while busy or in DONE is ignored. start held high continuously restarts from IDLE (one IDLE cycle between sweeps).
- Counter wrap: the vector counter is N_IN+1 bits internally so that the terminal count is detected without alias.

Test Plan:
- Ideal DUT (dut_out = exact), defaults -> done at cycle 17; max_err=0, mismatch_cnt=0, pass=1, worst_vec=0, fail_vec=0.
- Approximate DUT with out0 = in2&in3 | in1&in3 | ~in1 | in0, out1 = ~in0, out2 = 0, defaults -> max_err=3, mismatch_cnt=11, worst_vec=0, fail_vec=0, pass=1.
- Same DUT, ET=2, STOP_ON_FAIL=1 -> fail at vector 0; done in cycle 2; pass=0, fail_vec=0, max_err=3, mismatch_cnt=1.
- Ideal DUT modelled with a 2-cycle delay, DUT_LAT=2 -> done at cycle 19, max_err=0, pass=1; DUT_LAT=0 with the same delayed DUT -> mismatches > 0.
- rst_n low for 1 cycle at cycle 8 of a sweep -> next cycle all outputs 0, state IDLE, no done; a fresh start then completes normally.
- start pulsed at cycles 5 and 17 of a running sweep -> ignored; single done at cycle 17; results identical to an undisturbed run.
